// File: rtl/modmul_datapath.sv
// ---------------------------------------------------------------------------
// modmul_datapath
//
// Execution datapath of an interleaved (MSB-first, shift-and-add) modular
// multiplier computing C = A*B mod N. It holds the operand, modulus,
// multiplier, accumulator and bit-counter registers. Each cycle it executes
// the control word issued by the controller FSM and returns a combinational
// status word that the controller uses for its decisions.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low; clears every register
//   Control_Signal  [14] LoadA   [13] LoadN   [12] LoadCoun [11] LoadB
//                   [10] ShiftB  [9]  LoadC   [8]  ShiftC   [7]  S_Coun
//                   [6]  S_Comp1 [5]  S_Comp2 [4]  S_AS1    [3:2] S_AS2
//                   [1]  S_C (reserved)       [0]  AS (reserved)
//   A_in, B_in      multiplicand (must be below N) and multiplier
//   N_in            modulus, nonzero
//   Status_Signal   [2] S_Coun ? cnt==0 : S_Comp1 & (C>N)
//                   [1] S_Comp2 & (C==N)
//                   [0] current multiplier bit B[W-1]
//   Result          low W bits of the accumulator C
// ---------------------------------------------------------------------------
module modmul_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [14:0]  Control_Signal,
  input  logic [W-1:0] A_in,
  input  logic [W-1:0] B_in,
  input  logic [W-1:0] N_in,
  output logic [2:0]   Status_Signal,
  output logic [W-1:0] Result
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);

  // Control word fields
  logic       load_a;
  logic       load_n;
  logic       load_coun;
  logic       load_b;
  logic       shift_b;
  logic       load_c;
  logic       shift_c;
  logic       s_coun;
  logic       s_comp1;
  logic       s_comp2;
  logic       s_as1;
  logic [1:0] s_as2;
  logic       unused_reserved;

  assign load_a    = Control_Signal[14];
  assign load_n    = Control_Signal[13];
  assign load_coun = Control_Signal[12];
  assign load_b    = Control_Signal[11];
  assign shift_b   = Control_Signal[10];
  assign load_c    = Control_Signal[9];
  assign shift_c   = Control_Signal[8];
  assign s_coun    = Control_Signal[7];
  assign s_comp1   = Control_Signal[6];
  assign s_comp2   = Control_Signal[5];
  assign s_as1     = Control_Signal[4];
  assign s_as2     = Control_Signal[3:2];

  // S_C and AS are reserved: accepted but deliberately without effect.
  assign unused_reserved = ^Control_Signal[1:0];

  // Registers
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  b_q, b_d;
  logic [W:0]    c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accumulator arithmetic is one bit wider than the operands and wraps
  // modulo 2^(W+1); with A<N and C<N at iteration start C stays below 2N.
  logic [W:0] n_ext;
  logic [W:0] c_sub_n;
  logic [W:0] c_add_a;

  assign n_ext   = {1'b0, n_q};
  assign c_sub_n = c_q - n_ext;
  assign c_add_a = c_q + {1'b0, a_q};

  // Next-state selection for all registers; loads win over shifts.
  always_comb begin
    a_d   = a_q;
    n_d   = n_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;

    if (load_a) a_d = A_in;
    if (load_n) n_d = N_in;

    if (load_b)       b_d = B_in;
    else if (shift_b) b_d = {b_q[W-2:0], 1'b0};

    // Counter decrements saturate at zero so the controller can over-count.
    if (load_coun) begin
      if (!s_coun)             cnt_d = CNT_INIT;
      else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
    end

    // S_AS2 values 1 and 3 both select subtraction.
    if (load_c) begin
      if (!s_as1) begin
        c_d = '0;
      end else begin
        case (s_as2)
          2'd0:    c_d = c_q;
          2'd2:    c_d = c_add_a;
          default: c_d = c_sub_n;
        endcase
      end
    end else if (shift_c) begin
      c_d = {c_q[W-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      n_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      n_q   <= n_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  // Zero-latency status: the controller samples it in the same cycle it
  // sets the select bits. C>N and C==N are mutually exclusive, so [2:1]
  // never reads 11 in compare mode.
  always_comb begin
    Status_Signal[2] = s_coun ? (cnt_q == '0) : (s_comp1 & (c_q > n_ext));
    Status_Signal[1] = s_comp2 & (c_q == n_ext);
    Status_Signal[0] = b_q[W-1];
  end

  assign Result = c_q[W-1:0];

endmodule
